vga_scanout: RTL and testbench
==============================

VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 SHALL have parameters (name, default, meaning): HDISP 640 active pixels/line; HFP 16, HPULSE 96, HBP 48 horizontal porches/pulse (pixels); VDISP 480 active lines; VFP 11, VPULSE 2, VBP 31 vertical porches/pulse (lines); HS_POL 0 HS active level; VS_POL 0 VS active level; FMT 0 pixel format (0=RGB565, PIX_W=16; 1=RGB888, PIX_W=24).
REQ-002 SHALL have ports (name, direction, width, meaning): vga_CLK in 1 pixel clock; rst in 1 reset (synchronous, active-high); enable in 1 scanout enable; fifo_rdata in PIX_W show-ahead FIFO head; fifo_rempty in 1 FIFO empty; fifo_read out 1 pop FIFO head; VGA_R/VGA_G/VGA_B out 8 each colour; VGA_HS out 1; VGA_VS out 1; VGA_BLANK out 1 (0=blanking); VGA_SYNC out 1; frame_start out 1 pulse; resync_req out 1 writer restart request; underflow out 1 sticky flag; underflow_clr in 1 clear flag/count; underflow_cnt out 16 underflow event count.

Function
REQ-003 SHALL run h_cnt 0..HTOTAL-1 (HTOTAL=HDISP+HFP+HPULSE+HBP) and v_cnt 0..VTOTAL-1; v_cnt advances when h_cnt wraps; both wrap to 0 together at (HTOTAL-1, VTOTAL-1).
REQ-004 SHALL size counters by $clog2 of totals; all comparisons against parameter-derived constants.
REQ-005 SHALL define active = (h_cnt<HDISP)&&(v_cnt<VDISP).
REQ-006 SHALL register all video outputs; outputs lag counters by exactly 1 cycle.
REQ-007 SHALL drive VGA_HS=HS_POL when h_cnt in [HDISP+HFP, HDISP+HFP+HPULSE-1], else !HS_POL; VGA_VS likewise on v_cnt with VFP/VPULSE/VS_POL.
REQ-008 SHALL drive VGA_BLANK=active (registered); VGA_SYNC constant 0.
REQ-009 SHALL pulse frame_start 1 cycle, aligned with output of pixel (0,0).
REQ-010 SHALL implement FSM states IDLE, WAIT_FRAME, STREAM, RESYNC.
REQ-011 IDLE: counters held at 0, fifo_read=0, colours 0, syncs inactive, BLANK=0; enable=1 -> WAIT_FRAME.
REQ-012 WAIT_FRAME: counters run, fifo_read=0, colours 0; at (HTOTAL-1,VTOTAL-1) with fifo_rempty=0 -> STREAM, else stay.
REQ-013 STREAM: fifo_read=active&&!fifo_rempty (combinational); colours from fifo_rdata when read, else 0 outside active.
REQ-014 STREAM underflow (active&&fifo_rempty): output black that pixel, set underflow, increment underflow_cnt (saturate 0xFFFF), -> RESYNC.
REQ-015 RESYNC: resync_req=1, fifo_read=!fifo_rempty (flush), colours 0; at (HTOTAL-1,VTOTAL-1) -> WAIT_FRAME, resync_req falls.
REQ-016 enable=0 in any state -> IDLE next cycle, counters reset to 0; in-progress frame abandoned.
REQ-017 RGB565: R=rdata[15:11], G=[10:5], B=[4:0]; expand to 8 bits by MSB replication ({R5,R5[4:2]}, {G6,G6[5:4]}).
REQ-018 RGB888: R=rdata[23:16], G=[15:8], B=[7:0].
REQ-019 underflow_clr clears flag and count; same-cycle underflow event wins: flag=1, count=1.

Reset
REQ-020 rst SHALL force state IDLE, h_cnt=v_cnt=0, fifo_read=0, colours 0, HS=!HS_POL, VS=!VS_POL, BLANK=0, SYNC=0, frame_start=0, resync_req=0, underflow=0, underflow_cnt=0; mid-frame reset takes effect next edge, no FIFO pop in reset cycle.

Structure
REQ-021 SHALL place FSM state typedef, format enum and RGB565 expansion function in shared package vga_pkg.
REQ-022 SHALL contain one sub-module vga_timing (counters, HS/VS/active/frame-end); FSM, FIFO read and colour path in vga_scanout.

Verification (HDISP=8,HFP=2,HPULSE=3,HBP=2,VDISP=4,VFP=1,VPULSE=2,VBP=1; HTOTAL=15, VTOTAL=8)
REQ-023 Timing: enable=1, FIFO never empty -> HS low 3 cycles every 15, VS low 2 lines of 8, BLANK high 8 of 15 on lines 0-3, frame_start every 120 cycles.
REQ-024 Start: FIFO empty until cycle 200 then filled -> no fifo_read before next frame end; first frame_start coincides with first pixel pop.
REQ-025 Colour: FMT=0, rdata 0xF81F -> R=0xFF,G=0x00,B=0xFF; rdata 0x0841 -> R=0x08,G=0x08,B=0x08.
REQ-026 Underflow: rempty=1 at pixel (3,1) -> black, underflow=1, underflow_cnt=1, resync_req=1 until frame end, FIFO flushed, streaming resumes following frame.
REQ-027 Clear collision: underflow_clr in same cycle as 2nd underflow -> underflow=1, cnt=1; rst at pixel (5,2) -> all REQ-020 values next cycle, IDLE.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA scanout block.
//   state_t       : scanout controller states
//   pix_fmt_e     : FIFO pixel formats (RGB565 / RGB888)
//   pix_width()   : FIFO word width for a given format
//   rgb565_expand : RGB565 -> 24-bit colour by MSB replication
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_STREAM     = 2'd2,
    ST_RESYNC     = 2'd3
  } state_t;

  typedef enum logic {
    FMT_RGB565 = 1'b0,
    FMT_RGB888 = 1'b1
  } pix_fmt_e;

  function automatic int pix_width(input int fmt);
    return (fmt == int'(FMT_RGB888)) ? 24 : 16;
  endfunction

  // Replicating the top bits into the new LSBs maps full-scale 5/6-bit
  // values to 0xFF and zero to 0x00.
  function automatic logic [23:0] rgb565_expand(input logic [15:0] pix);
    return {pix[15:11], pix[15:13], pix[10:5], pix[10:9], pix[4:0], pix[4:2]};
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Show-ahead FIFO read port between the pixel FIFO and the scanout.
//   fifo_rdata  : head of FIFO (valid whenever fifo_rempty=0)
//   fifo_rempty : FIFO empty
//   fifo_read   : pop the head this cycle
// master = scanout (pops), slave = FIFO.
interface vga_scanout_if
  import vga_pkg::*;
#(
  parameter int PIX_W = pix_width(int'(FMT_RGB565))
);
  logic [PIX_W-1:0] fifo_rdata;
  logic             fifo_rempty;
  logic             fifo_read;

  modport master (input fifo_rdata, input fifo_rempty, output fifo_read);
  modport slave  (output fifo_rdata, output fifo_rempty, input fifo_read);
endinterface

// File: rtl/vga_timing.sv
// Raster counters and sync/active decode.
//   vga_CLK, rst : pixel clock, synchronous active-high reset
//   i_clear      : hold both counters at 0
//   o_h_cnt/o_v_cnt : current pixel/line position
//   o_active     : inside visible area
//   o_hs/o_vs    : combinational sync levels for the current position
//   o_frame_end  : last pixel of the frame (HTOTAL-1, VTOTAL-1)
module vga_timing #(
  parameter int HDISP  = 640,
  parameter int HFP    = 16,
  parameter int HPULSE = 96,
  parameter int HBP    = 48,
  parameter int VDISP  = 480,
  parameter int VFP    = 11,
  parameter int VPULSE = 2,
  parameter int VBP    = 31,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP,
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP,
  localparam int HW     = $clog2(HTOTAL),
  localparam int VW     = $clog2(VTOTAL)
) (
  input  logic          vga_CLK,
  input  logic          rst,
  input  logic          i_clear,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_active,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_frame_end
);

  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
  localparam logic [HW-1:0] H_DISP_C = HW'(HDISP);
  localparam logic [VW-1:0] V_DISP_C = VW'(VDISP);
  localparam logic [HW-1:0] HS_START = HW'(HDISP + HFP);
  localparam logic [HW-1:0] HS_END   = HW'(HDISP + HFP + HPULSE - 1);
  localparam logic [VW-1:0] VS_START = VW'(VDISP + VFP);
  localparam logic [VW-1:0] VS_END   = VW'(VDISP + VFP + VPULSE - 1);
  localparam logic          HS_ACT   = (HS_POL != 0);
  localparam logic          VS_ACT   = (VS_POL != 0);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;

  always_ff @(posedge vga_CLK) begin
    if (rst || i_clear) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_h_cnt     = r_h_cnt;
  assign o_v_cnt     = r_v_cnt;
  assign o_active    = (r_h_cnt < H_DISP_C) && (r_v_cnt < V_DISP_C);
  assign o_hs        = ((r_h_cnt >= HS_START) && (r_h_cnt <= HS_END)) ? HS_ACT : ~HS_ACT;
  assign o_vs        = ((r_v_cnt >= VS_START) && (r_v_cnt <= VS_END)) ? VS_ACT : ~VS_ACT;
  assign o_frame_end = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: pulls pixels from a show-ahead FIFO and drives a VGA DAC.
//   vga_CLK, rst        : pixel clock, synchronous active-high reset
//   enable              : run scanout; low returns to IDLE next cycle
//   fifo (master)       : FIFO read port (rdata/rempty in, read out)
//   VGA_R/G/B, HS, VS, BLANK, SYNC : registered video outputs (1-cycle lag)
//   frame_start         : 1-cycle pulse with pixel (0,0) of a streamed frame
//   resync_req          : asks the writer to restart after an underflow
//   underflow / underflow_cnt / underflow_clr : sticky flag + saturating count
// Streaming only starts on a frame boundary so the first popped word is
// always pixel (0,0); after an underflow the FIFO is flushed for the rest of
// the frame and the controller re-aligns at the next boundary.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int HDISP  = 640,
  parameter int HFP    = 16,
  parameter int HPULSE = 96,
  parameter int HBP    = 48,
  parameter int VDISP  = 480,
  parameter int VFP    = 11,
  parameter int VPULSE = 2,
  parameter int VBP    = 31,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int FMT    = 0
) (
  input  logic          vga_CLK,
  input  logic          rst,
  input  logic          enable,
  vga_scanout_if.master fifo,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK,
  output logic          VGA_SYNC,
  output logic          frame_start,
  output logic          resync_req,
  output logic          underflow,
  input  logic          underflow_clr,
  output logic [15:0]   underflow_cnt
);

  localparam int   PIX_W   = pix_width(FMT);
  localparam int   HW      = $clog2(HDISP + HFP + HPULSE + HBP);
  localparam int   VW      = $clog2(VDISP + VFP + VPULSE + VBP);
  localparam logic HS_IDLE = (HS_POL == 0);
  localparam logic VS_IDLE = (VS_POL == 0);

  state_t        r_state, w_state_next;
  logic          w_clear, w_run;
  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_active, w_hs, w_vs, w_frame_end;
  logic          w_fifo_read, w_pix_load, w_uf_event;
  logic [23:0]   w_rgb;

  logic [23:0]   r_rgb;
  logic          r_hs, r_vs, r_blank, r_frame_start, r_resync_req;
  logic          r_underflow;
  logic [15:0]   r_underflow_cnt;

  assign w_clear = !enable || (r_state == ST_IDLE);
  assign w_run   = enable && (r_state != ST_IDLE);

  vga_timing #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .vga_CLK    (vga_CLK),
    .rst        (rst),
    .i_clear    (w_clear),
    .o_h_cnt    (w_h_cnt),
    .o_v_cnt    (w_v_cnt),
    .o_active   (w_active),
    .o_hs       (w_hs),
    .o_vs       (w_vs),
    .o_frame_end(w_frame_end)
  );

  generate
    if (FMT == int'(FMT_RGB888)) begin : g_rgb888
      assign w_rgb = fifo.fifo_rdata[PIX_W-1:0];
    end else begin : g_rgb565
      assign w_rgb = rgb565_expand(fifo.fifo_rdata[PIX_W-1:0]);
    end
  endgenerate

  // Reset and disable are folded in here so no pop or underflow event can
  // happen in the cycle that abandons the frame.
  always_comb begin
    w_state_next = r_state;
    w_fifo_read  = 1'b0;
    w_pix_load   = 1'b0;
    w_uf_event   = 1'b0;
    if (rst || !enable) begin
      w_state_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: w_state_next = ST_WAIT_FRAME;
        ST_WAIT_FRAME: begin
          if (w_frame_end && !fifo.fifo_rempty) w_state_next = ST_STREAM;
        end
        ST_STREAM: begin
          if (w_active) begin
            if (!fifo.fifo_rempty) begin
              w_fifo_read = 1'b1;
              w_pix_load  = 1'b1;
            end else begin
              w_uf_event   = 1'b1;
              w_state_next = ST_RESYNC;
            end
          end
        end
        ST_RESYNC: begin
          // Drain whatever the writer left behind, including during blanking.
          w_fifo_read = !fifo.fifo_rempty;
          if (w_frame_end) w_state_next = ST_WAIT_FRAME;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  assign fifo.fifo_read = w_fifo_read;

  always_ff @(posedge vga_CLK) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge vga_CLK) begin
    if (rst) begin
      r_rgb         <= '0;
      r_hs          <= HS_IDLE;
      r_vs          <= VS_IDLE;
      r_blank       <= 1'b0;
      r_frame_start <= 1'b0;
      r_resync_req  <= 1'b0;
    end else begin
      r_rgb         <= w_pix_load ? w_rgb : 24'd0;
      r_hs          <= w_run ? w_hs : HS_IDLE;
      r_vs          <= w_run ? w_vs : VS_IDLE;
      r_blank       <= w_run && w_active;
      r_frame_start <= w_run && (r_state == ST_STREAM) && (w_h_cnt == '0) && (w_v_cnt == '0);
      r_resync_req  <= (w_state_next == ST_RESYNC);
    end
  end

  // An underflow in the same cycle as a clear counts as the first event.
  always_ff @(posedge vga_CLK) begin
    if (rst) begin
      r_underflow     <= 1'b0;
      r_underflow_cnt <= 16'd0;
    end else if (w_uf_event) begin
      r_underflow     <= 1'b1;
      if (underflow_clr)                   r_underflow_cnt <= 16'd1;
      else if (r_underflow_cnt != 16'hFFFF) r_underflow_cnt <= r_underflow_cnt + 16'd1;
    end else if (underflow_clr) begin
      r_underflow     <= 1'b0;
      r_underflow_cnt <= 16'd0;
    end
  end

  assign VGA_R         = r_rgb[23:16];
  assign VGA_G         = r_rgb[15:8];
  assign VGA_B         = r_rgb[7:0];
  assign VGA_HS        = r_hs;
  assign VGA_VS        = r_vs;
  assign VGA_BLANK     = r_blank;
  assign VGA_SYNC      = 1'b0;
  assign frame_start   = r_frame_start;
  assign resync_req    = r_resync_req;
  assign underflow     = r_underflow;
  assign underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout with a 15x8 raster (8x4 visible).
// Each step drives inputs just after a rising edge and samples at the
// falling edge; after a frame_start sample the next step sees counter
// position p = j+2 and the registered outputs of position j+1.
module tb_vga_scanout;

  logic        vga_CLK;
  logic        rst;
  logic        enable;
  logic        underflow_clr;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC;
  logic        frame_start, resync_req, underflow;
  logic [15:0] underflow_cnt;

  int tests_run = 0;
  int fails     = 0;

  logic        s_rd, s_hs, s_vs, s_blank, s_sync, s_fs, s_rr, s_uf;
  logic [7:0]  s_r, s_g, s_b;
  logic [15:0] s_cnt;

  vga_scanout_if #(.PIX_W(16)) fifo_if ();

  vga_scanout #(
    .HDISP(8), .HFP(2), .HPULSE(3), .HBP(2),
    .VDISP(4), .VFP(1), .VPULSE(2), .VBP(1),
    .HS_POL(0), .VS_POL(0), .FMT(0)
  ) dut (
    .vga_CLK      (vga_CLK),
    .rst          (rst),
    .enable       (enable),
    .fifo         (fifo_if),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B),
    .VGA_HS       (VGA_HS),
    .VGA_VS       (VGA_VS),
    .VGA_BLANK    (VGA_BLANK),
    .VGA_SYNC     (VGA_SYNC),
    .frame_start  (frame_start),
    .resync_req   (resync_req),
    .underflow    (underflow),
    .underflow_clr(underflow_clr),
    .underflow_cnt(underflow_cnt)
  );

  initial vga_CLK = 1'b0;
  always #5 vga_CLK = ~vga_CLK;

  task automatic step(input logic emp, input logic clr, input logic rst_v, input logic [15:0] data);
    fifo_if.fifo_rempty = emp;
    fifo_if.fifo_rdata  = data;
    underflow_clr       = clr;
    rst                 = rst_v;
    @(negedge vga_CLK);
    s_rd = fifo_if.fifo_read; s_hs = VGA_HS; s_vs = VGA_VS; s_blank = VGA_BLANK;
    s_sync = VGA_SYNC; s_fs = frame_start; s_rr = resync_req; s_uf = underflow;
    s_r = VGA_R; s_g = VGA_G; s_b = VGA_B; s_cnt = underflow_cnt;
    @(posedge vga_CLK);
    #1;
  endtask

  task automatic sync_frame(input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0841);
      if (s_fs) found = 1'b1;
    end
    tests_run++;
    if (!found) begin fails++; $display("FAIL sync_frame: no frame_start within %0d cycles", bound); end
  endtask

  task automatic test_reset();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'h1234);
    tests_run++; if (s_rd !== 1'b0) begin fails++; $display("FAIL reset_read: got %b want 0", s_rd); end
    tests_run++; if ({s_r, s_g, s_b} !== 24'h0) begin fails++; $display("FAIL reset_rgb: got %h want 000000", {s_r, s_g, s_b}); end
    tests_run++; if (s_hs !== 1'b1) begin fails++; $display("FAIL reset_hs: got %b want 1", s_hs); end
    tests_run++; if (s_vs !== 1'b1) begin fails++; $display("FAIL reset_vs: got %b want 1", s_vs); end
    tests_run++; if (s_blank !== 1'b0) begin fails++; $display("FAIL reset_blank: got %b want 0", s_blank); end
    tests_run++; if (s_sync !== 1'b0) begin fails++; $display("FAIL reset_sync: got %b want 0", s_sync); end
    tests_run++; if ({s_fs, s_rr, s_uf} !== 3'b000) begin fails++; $display("FAIL reset_flags: got fs/rr/uf=%b want 000", {s_fs, s_rr, s_uf}); end
    tests_run++; if (s_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", s_cnt); end
    $display("[TB] test_reset done");
  endtask

  // FIFO empty for the first 200 steps: frame end at step 120 is skipped,
  // the one at step 240 starts streaming.
  task automatic test_start();
    int first_rd = -1;
    int first_fs = -1;
    for (int k = 0; k < 260; k++) begin
      step((k < 200), 1'b0, 1'b0, 16'hF81F);
      if (s_rd && first_rd < 0) first_rd = k;
      if (s_fs && first_fs < 0) first_fs = k;
    end
    tests_run++; if (first_rd !== 241) begin fails++; $display("FAIL start_first_read: got step %0d want 241", first_rd); end
    tests_run++; if (first_fs !== 242) begin fails++; $display("FAIL start_first_frame_start: got step %0d want 242", first_fs); end
    $display("[TB] test_start done");
  endtask

  task automatic test_timing();
    int n_hs = 0, n_vs = 0, n_bl = 0, n_rd = 0, n_fs = 0, fs_at = -1;
    logic sync_seen = 1'b0;
    sync_frame(130);
    for (int j = 0; j < 120; j++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0841);
      if (s_hs == 1'b0) n_hs++;
      if (s_vs == 1'b0) n_vs++;
      if (s_blank == 1'b1) n_bl++;
      if (s_rd == 1'b1) n_rd++;
      if (s_fs == 1'b1) begin n_fs++; fs_at = j; end
      if (s_sync !== 1'b0) sync_seen = 1'b1;
      if (j == 8)  begin tests_run++; if (s_hs !== 1'b1) begin fails++; $display("FAIL hs_h9: got %b want 1", s_hs); end end
      if (j == 9)  begin tests_run++; if (s_hs !== 1'b0) begin fails++; $display("FAIL hs_h10: got %b want 0", s_hs); end end
      if (j == 11) begin tests_run++; if (s_hs !== 1'b0) begin fails++; $display("FAIL hs_h12: got %b want 0", s_hs); end end
      if (j == 12) begin tests_run++; if (s_hs !== 1'b1) begin fails++; $display("FAIL hs_h13: got %b want 1", s_hs); end end
      if (j == 73) begin tests_run++; if (s_vs !== 1'b1) begin fails++; $display("FAIL vs_v4: got %b want 1", s_vs); end end
      if (j == 74) begin tests_run++; if (s_vs !== 1'b0) begin fails++; $display("FAIL vs_v5: got %b want 0", s_vs); end end
      if (j == 103) begin tests_run++; if (s_vs !== 1'b0) begin fails++; $display("FAIL vs_v6: got %b want 0", s_vs); end end
      if (j == 104) begin tests_run++; if (s_vs !== 1'b1) begin fails++; $display("FAIL vs_v7: got %b want 1", s_vs); end end
      if (j == 6)  begin tests_run++; if (s_blank !== 1'b1) begin fails++; $display("FAIL blank_h7: got %b want 1", s_blank); end end
      if (j == 7)  begin tests_run++; if (s_blank !== 1'b0) begin fails++; $display("FAIL blank_h8: got %b want 0", s_blank); end end
      if (j == 44) begin tests_run++; if (s_blank !== 1'b1) begin fails++; $display("FAIL blank_v3: got %b want 1", s_blank); end end
      if (j == 59) begin tests_run++; if (s_blank !== 1'b0) begin fails++; $display("FAIL blank_v4: got %b want 0", s_blank); end end
    end
    tests_run++; if (n_hs !== 24) begin fails++; $display("FAIL hs_count: got %0d want 24", n_hs); end
    tests_run++; if (n_vs !== 30) begin fails++; $display("FAIL vs_count: got %0d want 30", n_vs); end
    tests_run++; if (n_bl !== 32) begin fails++; $display("FAIL blank_count: got %0d want 32", n_bl); end
    tests_run++; if (n_rd !== 32) begin fails++; $display("FAIL read_count: got %0d want 32", n_rd); end
    tests_run++; if (n_fs !== 1 || fs_at !== 119) begin fails++; $display("FAIL frame_period: got %0d pulses at %0d want 1 at 119", n_fs, fs_at); end
    tests_run++; if (sync_seen !== 1'b0) begin fails++; $display("FAIL sync_const: got %b want 0", sync_seen); end
    $display("[TB] test_timing done");
  endtask

  task automatic test_colour();
    sync_frame(130);
    for (int j = 0; j < 9; j++) begin
      step(1'b0, 1'b0, 1'b0, (j < 3) ? 16'hF81F : 16'h0841);
      if (j == 1) begin
        tests_run++;
        if ({s_r, s_g, s_b} !== 24'hFF00FF) begin fails++; $display("FAIL colour_f81f: got %h want ff00ff", {s_r, s_g, s_b}); end
      end
      if (j == 5) begin
        tests_run++;
        if ({s_r, s_g, s_b} !== 24'h080808) begin fails++; $display("FAIL colour_0841: got %h want 080808", {s_r, s_g, s_b}); end
      end
      if (j == 8) begin
        tests_run++;
        if ({s_r, s_g, s_b} !== 24'h000000) begin fails++; $display("FAIL colour_blanking: got %h want 000000", {s_r, s_g, s_b}); end
      end
    end
    $display("[TB] test_colour done");
  endtask

  // Empty at pixel (3,1) -> j=16.
  task automatic test_underflow();
    int rd_wait = 0;
    int first_rd = -1;
    sync_frame(130);
    for (int j = 0; j < 241; j++) begin
      step((j == 16), 1'b0, 1'b0, 16'hFFFF);
      if (j == 16) begin tests_run++; if (s_rd !== 1'b0) begin fails++; $display("FAIL uf_no_pop: got %b want 0", s_rd); end end
      if (j == 17) begin
        tests_run++; if ({s_r, s_g, s_b} !== 24'h0) begin fails++; $display("FAIL uf_black: got %h want 000000", {s_r, s_g, s_b}); end
        tests_run++; if (s_uf !== 1'b1) begin fails++; $display("FAIL uf_flag: got %b want 1", s_uf); end
        tests_run++; if (s_cnt !== 16'd1) begin fails++; $display("FAIL uf_cnt: got %0d want 1", s_cnt); end
        tests_run++; if (s_rr !== 1'b1) begin fails++; $display("FAIL uf_resync_rise: got %b want 1", s_rr); end
        tests_run++; if (s_blank !== 1'b1) begin fails++; $display("FAIL uf_blank: got %b want 1", s_blank); end
      end
      if (j == 20) begin
        tests_run++; if (s_rd !== 1'b1) begin fails++; $display("FAIL flush_active: got %b want 1", s_rd); end
        tests_run++; if ({s_r, s_g, s_b} !== 24'h0) begin fails++; $display("FAIL resync_black: got %h want 000000", {s_r, s_g, s_b}); end
      end
      if (j == 25) begin tests_run++; if (s_rd !== 1'b1) begin fails++; $display("FAIL flush_blanking: got %b want 1", s_rd); end end
      if (j == 117) begin tests_run++; if (s_rr !== 1'b1) begin fails++; $display("FAIL resync_hold: got %b want 1", s_rr); end end
      if (j == 118) begin tests_run++; if (s_rr !== 1'b0) begin fails++; $display("FAIL resync_fall: got %b want 0", s_rr); end end
      if (j >= 118 && j <= 237 && s_rd) rd_wait++;
      if (j >= 118 && s_rd && first_rd < 0) first_rd = j;
      if (j == 239) begin tests_run++; if (s_fs !== 1'b1) begin fails++; $display("FAIL resume_frame_start: got %b want 1", s_fs); end end
    end
    tests_run++; if (rd_wait !== 0) begin fails++; $display("FAIL wait_frame_reads: got %0d want 0", rd_wait); end
    tests_run++; if (first_rd !== 238) begin fails++; $display("FAIL resume_read: got step %0d want 238", first_rd); end
    $display("[TB] test_underflow done");
  endtask

  task automatic test_clear_collision();
    sync_frame(130);
    for (int j = 0; j < 21; j++) begin
      step((j == 16), (j == 16) || (j == 18), 1'b0, 16'hFFFF);
      if (j == 17) begin
        tests_run++; if (s_uf !== 1'b1) begin fails++; $display("FAIL collide_flag: got %b want 1", s_uf); end
        tests_run++; if (s_cnt !== 16'd1) begin fails++; $display("FAIL collide_cnt: got %0d want 1", s_cnt); end
      end
      if (j == 19) begin
        tests_run++; if (s_uf !== 1'b0) begin fails++; $display("FAIL clear_flag: got %b want 0", s_uf); end
        tests_run++; if (s_cnt !== 16'd0) begin fails++; $display("FAIL clear_cnt: got %0d want 0", s_cnt); end
      end
    end
    $display("[TB] test_clear_collision done");
  endtask

  // Reset at pixel (5,2) -> j=33; restart from IDLE gives first pop at j=155.
  task automatic test_reset_mid();
    int first_rd = -1;
    sync_frame(400);
    for (int j = 0; j < 161; j++) begin
      step(1'b0, 1'b0, (j == 33), 16'h0841);
      if (j == 33) begin tests_run++; if (s_rd !== 1'b0) begin fails++; $display("FAIL midrst_no_pop: got %b want 0", s_rd); end end
      if (j == 34) begin
        tests_run++; if ({s_r, s_g, s_b} !== 24'h0) begin fails++; $display("FAIL midrst_rgb: got %h want 000000", {s_r, s_g, s_b}); end
        tests_run++; if ({s_hs, s_vs} !== 2'b11) begin fails++; $display("FAIL midrst_sync: got hs/vs=%b want 11", {s_hs, s_vs}); end
        tests_run++; if (s_blank !== 1'b0) begin fails++; $display("FAIL midrst_blank: got %b want 0", s_blank); end
        tests_run++; if ({s_fs, s_rr, s_uf, s_sync} !== 4'b0000) begin fails++; $display("FAIL midrst_flags: got %b want 0000", {s_fs, s_rr, s_uf, s_sync}); end
        tests_run++; if (s_cnt !== 16'd0) begin fails++; $display("FAIL midrst_cnt: got %0d want 0", s_cnt); end
      end
      if (j >= 34 && s_rd && first_rd < 0) first_rd = j;
    end
    tests_run++; if (first_rd !== 155) begin fails++; $display("FAIL midrst_restart: got step %0d want 155", first_rd); end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    rst                 = 1'b1;
    enable              = 1'b0;
    underflow_clr       = 1'b0;
    fifo_if.fifo_rempty = 1'b1;
    fifo_if.fifo_rdata  = 16'h0000;
    test_reset();
    test_start();
    test_timing();
    test_colour();
    test_underflow();
    test_clear_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
